// File: rtl/knight_pkg.sv
`default_nettype none
// ============================================================================
// Module   : knight_pkg
// Brief    : Shared constants, state encoding and command packing helper for
//            the knight's-tour command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package knight_pkg;

    // Moves per tour on a 5x5 board
    localparam int C_NUM_MOVES = 24;

    // cmd_proc opcodes
    localparam logic [3:0] C_OP_MOVE     = 4'h4;
    localparam logic [3:0] C_OP_MOVE_FAN = 4'h5;

    // cmd_proc headings
    localparam logic [7:0] C_HDG_N = 8'h00;
    localparam logic [7:0] C_HDG_W = 8'h3F;
    localparam logic [7:0] C_HDG_S = 8'h7F;
    localparam logic [7:0] C_HDG_E = 8'hBF;

    // Response bytes
    localparam logic [7:0] C_RESP_BUSY = 8'h5A;
    localparam logic [7:0] C_RESP_DONE = 8'hA5;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VERT   = 3'd1,
        ST_WAIT_V = 3'd2,
        ST_HORZ   = 3'd3,
        ST_WAIT_H = 3'd4
    } tour_state_e;

    // Pack a cmd_proc command word {opcode, heading, squares}
    function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage
`default_nettype wire

// File: rtl/knight_move_lut.sv
`default_nettype none
// ============================================================================
// Module   : knight_move_lut
// Brief    : Decodes a one-hot knight move into its vertical and horizontal
//            cmd_proc legs. Non-one-hot inputs flag illegal and yield
//            zero-square northward legs.
// Revision : 1.0 - initial release
// ============================================================================
module knight_move_lut
    import knight_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd,
    output logic        illegal
);

    // One-hot move to leg decode; bit n encodes a fixed (dx,dy) offset
    always_comb begin
        vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_N, 4'd0);
        horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_N, 4'd0);
        illegal  = 1'b0;
        case (move)
            8'h01: begin // (+1,+2)
                vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_N, 4'd2);
                horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_E, 4'd1);
            end
            8'h02: begin // (-1,+2)
                vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_N, 4'd2);
                horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_W, 4'd1);
            end
            8'h04: begin // (-2,+1)
                vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_N, 4'd1);
                horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_W, 4'd2);
            end
            8'h08: begin // (-2,-1)
                vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_S, 4'd1);
                horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_W, 4'd2);
            end
            8'h10: begin // (-1,-2)
                vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_S, 4'd2);
                horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_W, 4'd1);
            end
            8'h20: begin // (+1,-2)
                vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_S, 4'd2);
                horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_E, 4'd1);
            end
            8'h40: begin // (+2,-1)
                vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_S, 4'd1);
                horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_E, 4'd2);
            end
            8'h80: begin // (+2,+1)
                vert_cmd = mk_cmd(C_OP_MOVE,     C_HDG_N, 4'd1);
                horz_cmd = mk_cmd(C_OP_MOVE_FAN, C_HDG_E, 4'd2);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tour_cmd_seq
// Brief    : Sequences a solved knight's tour into cmd_proc commands (vertical
//            leg, then horizontal leg with fanfare per move) and passes UART
//            commands straight through outside a tour.
//            Optional macro TOUR_MOVE_CHECK_EN adds a sticky mv_err output and
//            aborts the tour on a non-one-hot move.
// Revision : 1.0 - initial release
// ============================================================================
module tour_cmd_seq
    import knight_pkg::*;
#(
    parameter  int NUM_MOVES = C_NUM_MOVES,
    localparam int IW        = $clog2(NUM_MOVES)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          start_tour,
    input  logic [7:0]    move,
    output logic [IW-1:0] mv_indx,
    input  logic [15:0]   cmd_UART,
    input  logic          cmd_rdy_UART,
    input  logic          clr_cmd_rdy,
    input  logic          send_resp,
`ifdef TOUR_MOVE_CHECK_EN
    output logic          mv_err,
`endif
    output logic [15:0]   cmd,
    output logic          cmd_rdy,
    output logic [7:0]    resp
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_VERT   = ST_VERT;
    localparam logic [2:0] S_WAIT_V = ST_WAIT_V;
    localparam logic [2:0] S_HORZ   = ST_HORZ;
    localparam logic [2:0] S_WAIT_H = ST_WAIT_H;

    localparam logic [IW-1:0] C_LAST = IW'(NUM_MOVES - 1);

    logic [2:0]    r_state;
    logic [IW-1:0] r_mv_indx;
    logic [15:0]   w_vert_cmd;
    logic [15:0]   w_horz_cmd;
    logic          w_illegal;
    logic          w_last;

    knight_move_lut u_lut (
        .move     (move),
        .vert_cmd (w_vert_cmd),
        .horz_cmd (w_horz_cmd),
        .illegal  (w_illegal)
    );

    assign w_last  = (r_mv_indx == C_LAST);
    assign mv_indx = r_mv_indx;

`ifdef TOUR_MOVE_CHECK_EN
    logic r_mv_err;
    assign mv_err = r_mv_err;

    // Sticky illegal-move flag, set when VERT sees a non-one-hot move
    always_ff @(posedge clk) begin
        if (rst)
            r_mv_err <= 1'b0;
        else if (r_state == S_VERT && w_illegal)
            r_mv_err <= 1'b1;
    end
`else
    // Illegal moves fall through to zero-square legs; flag is not needed
    logic w_unused_illegal;
    assign w_unused_illegal = w_illegal;
`endif

    // Tour FSM and move index counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mv_indx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_tour) begin
                        r_state   <= S_VERT;
                        r_mv_indx <= '0;
                    end
                end
                S_VERT: begin
`ifdef TOUR_MOVE_CHECK_EN
                    if (w_illegal) begin
                        r_state   <= S_IDLE;
                        r_mv_indx <= '0;
                    end else if (clr_cmd_rdy)
                        r_state <= S_WAIT_V;
`else
                    if (clr_cmd_rdy)
                        r_state <= S_WAIT_V;
`endif
                end
                S_WAIT_V: begin
                    if (send_resp)
                        r_state <= S_HORZ;
                end
                S_HORZ: begin
                    if (clr_cmd_rdy)
                        r_state <= S_WAIT_H;
                end
                S_WAIT_H: begin
                    if (send_resp) begin
                        if (w_last) begin
                            r_state   <= S_IDLE;
                            r_mv_indx <= '0;
                        end else begin
                            r_state   <= S_VERT;
                            r_mv_indx <= r_mv_indx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output muxing: UART pass-through in IDLE, tour legs otherwise
    always_comb begin
        cmd     = w_vert_cmd;
        cmd_rdy = 1'b0;
        resp    = C_RESP_BUSY;
        case (r_state)
            S_IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = C_RESP_DONE;
            end
            S_VERT: begin
                cmd = w_vert_cmd;
`ifdef TOUR_MOVE_CHECK_EN
                cmd_rdy = ~w_illegal;
`else
                cmd_rdy = 1'b1;
`endif
            end
            S_WAIT_V: cmd = w_vert_cmd;
            S_HORZ: begin
                cmd     = w_horz_cmd;
                cmd_rdy = 1'b1;
            end
            S_WAIT_H: begin
                cmd  = w_horz_cmd;
                resp = w_last ? C_RESP_DONE : C_RESP_BUSY;
            end
            default: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = C_RESP_DONE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tour_cmd_seq
// Brief    : Self-checking bench for tour_cmd_seq with a tour memory and a
//            cmd_proc model. Honours TOUR_MOVE_CHECK_EN for the mv_err port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tour_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;
`ifdef TOUR_MOVE_CHECK_EN
    logic        mv_err;
`endif

    logic [7:0]  r_mem [0:31];
    logic [15:0] q_exp [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_legs = 0;

    always #5 clk = ~clk;

    assign move = r_mem[mv_indx];

    tour_cmd_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
`ifdef TOUR_MOVE_CHECK_EN
        .mv_err       (mv_err),
`endif
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .resp         (resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference leg model built from the (dx,dy) table of each move bit
    task automatic model_legs(input logic [7:0] mv, output logic [15:0] v, output logic [15:0] h);
        int dx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
        int dy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
        v = 16'h4000;
        h = 16'h5000;
        if ($onehot(mv)) begin
            for (int b = 0; b < 8; b++) begin
                if (mv[b]) begin
                    v = {4'h4, (dy[b] > 0) ? 8'h00 : 8'h7F, 4'((dy[b] > 0) ? dy[b] : -dy[b])};
                    h = {4'h5, (dx[b] > 0) ? 8'hBF : 8'h3F, 4'((dx[b] > 0) ? dx[b] : -dx[b])};
                end
            end
        end
    endtask

    task automatic push_tour(input int n);
        logic [15:0] v, h;
        for (int i = 0; i < n; i++) begin
            model_legs(r_mem[i], v, h);
            q_exp.push_back(v);
            q_exp.push_back(h);
        end
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // cmd_proc model: wait for cmd_rdy, compare, capture, then respond
    task automatic serve_leg(input logic [7:0] exp_resp, input bit poke_start,
                             input bit use_lit, input logic [15:0] lit);
        bit ok = 1'b0;
        logic [15:0] e;
        for (int i = 0; i < 20; i++) begin
            if (cmd_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("leg_rdy_timeout", {31'd0, ok}, 32'd1);
        if (!ok) return;
        n_legs++;
        e = (q_exp.size() > 0) ? q_exp.pop_front() : 16'hxxxx;
        check("leg_cmd", {16'd0, cmd}, {16'd0, e});
        if (use_lit)
            check("leg_cmd_literal", {16'd0, cmd}, {16'd0, lit});
        if (poke_start) begin
            pulse_start();
            check("start_in_horz_ignored", {31'd0, cmd_rdy}, 32'd1);
        end
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check("wait_rdy_low", {31'd0, cmd_rdy}, 32'd0);
        tick();
        check("wait_resp", {24'd0, resp}, {24'd0, exp_resp});
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
    endtask

    initial begin : main
        logic [15:0] lits [6] = '{16'h4002, 16'h5BF1, 16'h47F1, 16'h53F2, 16'h4001, 16'h5BF2};
        rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        for (int i = 0; i < 32; i++) r_mem[i] = 8'h01 << $urandom_range(0, 7);
        r_mem[0] = 8'h01; r_mem[1] = 8'h08; r_mem[2] = 8'h80;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("reset_mv_indx", {27'd0, mv_indx}, 32'd0);
        check("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("reset_resp", {24'd0, resp}, 32'hA5);
`ifdef TOUR_MOVE_CHECK_EN
        check("reset_mv_err", {31'd0, mv_err}, 32'd0);
`endif

        // Idle pass-through, same cycle
        cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1;
        #1;
        check("idle_cmd", {16'd0, cmd}, 32'h2000);
        check("idle_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("idle_resp", {24'd0, resp}, 32'hA5);
        tick();

        // Full tour; UART stays asserted to show it is not forwarded
        push_tour(24);
        pulse_start();
        for (int m = 0; m < 24; m++) begin
            serve_leg(8'h5A, 1'b0, (m < 3), lits[(m < 3) ? 2*m : 0]);
            serve_leg((m == 23) ? 8'hA5 : 8'h5A, (m == 0), (m < 3), lits[(m < 3) ? 2*m+1 : 0]);
        end
        check("tour_leg_count", n_legs, 32'd48);
        check("tour_end_mv_indx", {27'd0, mv_indx}, 32'd0);
        check("tour_end_cmd", {16'd0, cmd}, 32'h2000);
        check("tour_end_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        check("tour_end_resp", {24'd0, resp}, 32'hA5);
        check("scoreboard_empty", q_exp.size(), 32'd0);

        // Reset abandons a tour in move 10 WAIT_V
        cmd_rdy_UART = 1'b0;
        push_tour(24);
        pulse_start();
        for (int m = 0; m < 10; m++) begin
            serve_leg(8'h5A, 1'b0, 1'b0, 16'h0);
            serve_leg(8'h5A, 1'b0, 1'b0, 16'h0);
        end
        for (int i = 0; i < 20 && cmd_rdy !== 1'b1; i++) tick();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check("pre_rst_mv_indx", {27'd0, mv_indx}, 32'd10);
        check("pre_rst_resp", {24'd0, resp}, 32'h5A);
        do_reset();
        q_exp.delete();
        check("post_rst_mv_indx", {27'd0, mv_indx}, 32'd0);
        check("post_rst_cmd_rdy_lo", {31'd0, cmd_rdy}, 32'd0);
        check("post_rst_resp", {24'd0, resp}, 32'hA5);
        cmd_rdy_UART = 1'b1;
        #1;
        check("post_rst_cmd_rdy_hi", {31'd0, cmd_rdy}, 32'd1);
        tick();
        cmd_rdy_UART = 1'b0;

        // Non-one-hot move
        r_mem[0] = 8'h03;
`ifdef TOUR_MOVE_CHECK_EN
        pulse_start();
        check("illegal_vert_no_rdy", {31'd0, cmd_rdy}, 32'd0);
        tick();
        check("illegal_mv_err", {31'd0, mv_err}, 32'd1);
        check("illegal_idle_resp", {24'd0, resp}, 32'hA5);
        check("illegal_idle_mv_indx", {27'd0, mv_indx}, 32'd0);
        tick();
        check("illegal_mv_err_sticky", {31'd0, mv_err}, 32'd1);
`else
        push_tour(1);
        pulse_start();
        serve_leg(8'h5A, 1'b0, 1'b1, 16'h4000);
        serve_leg(8'h5A, 1'b0, 1'b1, 16'h5000);
        check("illegal_next_mv_indx", {27'd0, mv_indx}, 32'd1);
`endif
        do_reset();
        check("final_resp", {24'd0, resp}, 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
